// File: rtl/regfile_dumper.sv
// Register-file debug readout: walks read port A over [first_reg..last_reg] (wrapping)
// and streams (index, value) words on a valid/ready port. Optional trailing XOR word: REGDUMP_CHECKSUM_EN.
module regfile_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [DATA_WIDTH-1:0] data_readRegA,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_reg,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [ADDR_WIDTH-1:0] out_reg_q, out_reg_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hs_s;
  logic [ADDR_WIDTH-1:0] ptr_inc_s;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
`endif

  assign hs_s          = out_valid_q & out_ready;
  assign ptr_inc_s     = (ptr_q == ADDR_WIDTH'(NUM_REGS - 1)) ? '0 : ptr_q + ADDR_WIDTH'(1);
  assign ctrl_readRegA = ptr_q;
  assign out_valid     = out_valid_q;
  assign out_reg       = out_reg_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    out_reg_d   = out_reg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d   = first_reg;
          end_d   = last_reg;
`ifdef REGDUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        out_data_d  = data_readRegA;
        out_reg_d   = ptr_q;
        out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (ptr_q == end_q);
`endif
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (hs_s) begin
`ifdef REGDUMP_CHECKSUM_EN
          acc_d = acc_q ^ out_data_q;
`endif
          if (ptr_q == end_q) begin
`ifdef REGDUMP_CHECKSUM_EN
            // Checksum word is formed directly from the final data word being accepted.
            out_reg_d   = '0;
            out_data_d  = acc_q ^ out_data_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            state_d     = ST_CSUM;
`else
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_DONE;
`endif
          end else begin
            ptr_d       = ptr_inc_s;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = ST_FETCH;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (hs_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_CSUM;
        end
      end
`endif
      ST_DONE: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      out_reg_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      out_reg_q   <= out_reg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: a reference model queues the expected word stream
// for each dump; an independent monitor pops and compares on every handshake.
module tb_regfile_dumper;

  localparam int NR = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    logic        l;
  } word_t;

  logic        clock = 1'b0;
  logic        ctrl_reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_reg = 5'd0;
  logic [4:0]  last_reg = 5'd0;
  logic [4:0]  ctrl_readRegA;
  logic [31:0] data_readRegA;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_reg;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] regs [NR];
  word_t       exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          pops = 0;
  int          done_seen = 0;
  int          done_at = 0;
  int          cyc_cnt = 0;

  regfile_dumper dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n), .start(start),
    .first_reg(first_reg), .last_reg(last_reg),
    .ctrl_readRegA(ctrl_readRegA), .data_readRegA(data_readRegA),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  assign data_readRegA = regs[ctrl_readRegA];

  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_regs();
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
  endtask

  // Monitor: samples 1 unit after the falling edge, i.e. the values the next rising edge will see.
  initial begin : monitor
    logic        prev_v, prev_hs, exp_done;
    logic [4:0]  prev_r;
    logic [31:0] prev_d;
    logic        prev_l;
    word_t       w;
    prev_v = 1'b0; prev_hs = 1'b0; exp_done = 1'b0;
    prev_r = '0; prev_d = '0; prev_l = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (!ctrl_reset_n) begin
        prev_v = 1'b0;
        exp_done = 1'b0;
        continue;
      end
      if (exp_done) begin
        chk("done_pulse", {done, out_valid}, 2'b10);
        exp_done = 1'b0;
        done_at = cyc_cnt;
        done_seen++;
      end else if (done) begin
        chk("unexpected_done", done, 1'b0);
      end
      if (prev_v && !prev_hs) begin
        chk("stall_stable", {out_valid, out_reg, out_data, out_last}, {1'b1, prev_r, prev_d, prev_l});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {out_reg, out_data}, 37'd0 - 37'd1);
        end else begin
          w = exp_q.pop_front();
          chk("word", {out_reg, out_data, out_last}, {w.r, w.d, w.l});
          if (w.l) exp_done = 1'b1;
        end
        pops++;
      end
      prev_v  = out_valid;
      prev_hs = out_valid && out_ready;
      prev_r  = out_reg;
      prev_d  = out_data;
      prev_l  = out_last;
    end
  end

  // mode 0: ready always high (latency checked); 1: random ready; 2: 10-cycle stall on word 2;
  // 3: random ready plus spurious start pulses and range changes while busy.
  task automatic run_dump(input int f, input int l, input int mode);
    int          n, cyc, d0, base, stall, s;
    logic [31:0] acc;
    word_t       w;
    n = ((l - f + NR) % NR) + 1;
    acc = 32'd0;
    for (int k = 0; k < n; k++) begin
      w.r = 5'((f + k) % NR);
      w.d = regs[(f + k) % NR];
      w.l = !CSUM && (k == n - 1);
      acc ^= w.d;
      exp_q.push_back(w);
    end
    if (CSUM) begin
      w.r = 5'd0; w.d = acc; w.l = 1'b1;
      exp_q.push_back(w);
    end
    d0 = done_seen; base = pops; stall = 0; cyc = 0;
    @(negedge clock);
    first_reg = 5'(f); last_reg = 5'(l); start = 1'b1;
    out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    s = cyc_cnt;
    forever begin
      @(negedge clock);
      start = 1'b0;
      if (done_seen != d0) break;
      if (cyc >= 3000) begin
        chk("dump_timeout", 1'b1, 1'b0);
        exp_q.delete();
        break;
      end
      cyc++;
      case (mode)
        0: out_ready = 1'b1;
        2: begin
          out_ready = !((pops - base == 2) && out_valid && stall < 10);
          if (!out_ready) stall++;
        end
        3: begin
          out_ready = ($urandom_range(0, 3) != 0);
          start = ($urandom_range(0, 2) == 0);
          first_reg = 5'($urandom);
          last_reg = 5'($urandom);
        end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
    start = 1'b0;
    if (mode == 0) chk("done_latency", 64'(done_at - s), 64'(2 * n + 1 + (CSUM ? 1 : 0)));
    if (mode == 2) chk("stall_cycles", 64'(stall), 64'd10);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("idle_after_done", busy, 1'b0);
    out_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    fill_regs();
    #1;
    chk("reset_outputs", {out_valid, out_last, busy, done, out_reg, out_data, ctrl_readRegA}, 64'd0);
    repeat (3) @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(negedge clock);

    run_dump(0, 31, 0);
    fill_regs();
    regs[5] = 32'hDEADBEEF;
    run_dump(5, 5, 0);
    fill_regs();
    run_dump(30, 1, 3);
    fill_regs();
    run_dump(0, 7, 2);

    // Reset while a word is waiting in SEND.
    fill_regs();
    @(negedge clock);
    first_reg = 5'd3; last_reg = 5'd10; start = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("valid_before_reset", out_valid, 1'b1);
    @(negedge clock);
    ctrl_reset_n = 1'b0;
    start = 1'b1;
    exp_q.delete();
    #1;
    chk("async_reset", {out_valid, out_last, busy, done, out_reg, out_data, ctrl_readRegA}, 64'd0);
    @(negedge clock);
    chk("reset_beats_start", busy, 1'b0);
    start = 1'b0;
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    run_dump(3, 10, 1);

    fill_regs();
    regs[1] = 32'h1; regs[2] = 32'h2; regs[3] = 32'h4;
    run_dump(1, 3, 0);

    for (int t = 0; t < 8; t++) begin
      fill_regs();
      run_dump($urandom_range(0, NR - 1), $urandom_range(0, NR - 1), 1);
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
